// File: rtl/conv_layer_seq.sv
// Time-multiplexed valid-mode 2-D convolution layer with one signed fixed-point MAC and a valid/ready pixel stream.
// Build option: define CONV_LAYER_SEQ_RELU_EN to clamp negative results to zero.
module conv_layer_seq #(
    parameter int BITWIDTH = 16,
    parameter int FRAC     = 8,
    parameter int IN_CH    = 2,
    parameter int OUT_CH   = 2,
    parameter int KSIZE    = 5,
    parameter int IN_DIM   = 14,
    localparam int OUT_DIM = IN_DIM - KSIZE + 1,
    localparam int N       = IN_CH * KSIZE * KSIZE,
    localparam int OCW     = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
    localparam int ODW     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic signed [BITWIDTH-1:0] featuremap [IN_CH][IN_DIM][IN_DIM],
    input  logic signed [BITWIDTH-1:0] kernel [OUT_CH][IN_CH][KSIZE][KSIZE],
    output logic                       busy,
    output logic                       done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [BITWIDTH-1:0] out_data,
    output logic [OCW-1:0]             out_ch,
    output logic [ODW-1:0]             out_row,
    output logic [ODW-1:0]             out_col
);
    localparam int ICW  = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int KW   = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam int IDW  = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int PW   = 2 * BITWIDTH;
    localparam int ACCW = PW + $clog2(N);
    localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MINV = ~MAXV;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]                state_reg;
    logic [ICW-1:0]            c_reg;
    logic [KW-1:0]             kr_reg, kc_reg;
    logic signed [PW-1:0]      prod_reg;
    logic signed [ACCW-1:0]    acc_reg;
    logic                      last_reg;
    logic signed [BITWIDTH-1:0] data_reg;
    logic [OCW-1:0]            ch_reg;
    logic [ODW-1:0]            row_reg, col_reg;

    logic                      emit, col_wrap, row_wrap, last_pix;
    logic [OCW-1:0]            nxt_ch, sel_ch;
    logic [ODW-1:0]            nxt_row, nxt_col, sel_row, sel_col;
    logic [IDW-1:0]            fm_r, fm_c;
    logic                      kc_end, kr_end, c_end, tap_last;
    logic [KW-1:0]             kc_next, kr_next;
    logic [ICW-1:0]            c_next;
    logic signed [PW-1:0]      prod;
    logic signed [ACCW-1:0]    sum, shifted;
    logic signed [BITWIDTH-1:0] sat_val, res_val;

    assign emit     = (state_reg == S_EMIT);
    assign col_wrap = (col_reg == ODW'(OUT_DIM - 1));
    assign row_wrap = (row_reg == ODW'(OUT_DIM - 1));
    assign last_pix = col_wrap && row_wrap && (ch_reg == OCW'(OUT_CH - 1));
    assign nxt_col  = col_wrap ? '0 : col_reg + 1'b1;
    assign nxt_row  = col_wrap ? (row_wrap ? '0 : row_reg + 1'b1) : row_reg;
    assign nxt_ch   = (col_wrap && row_wrap) ? ch_reg + 1'b1 : ch_reg;

    // In EMIT the first product of the following pixel is fetched so the pixel loop costs N+1 cycles.
    assign sel_ch  = emit ? nxt_ch  : ch_reg;
    assign sel_row = emit ? nxt_row : row_reg;
    assign sel_col = emit ? nxt_col : col_reg;
    assign fm_r    = IDW'(sel_row) + IDW'(kr_reg);
    assign fm_c    = IDW'(sel_col) + IDW'(kc_reg);
    assign prod    = featuremap[c_reg][fm_r][fm_c] * kernel[sel_ch][c_reg][kr_reg][kc_reg];

    assign kc_end   = (kc_reg == KW'(KSIZE - 1));
    assign kr_end   = (kr_reg == KW'(KSIZE - 1));
    assign c_end    = (c_reg == ICW'(IN_CH - 1));
    assign tap_last = kc_end && kr_end && c_end;
    assign kc_next  = kc_end ? '0 : kc_reg + 1'b1;
    assign kr_next  = kc_end ? (kr_end ? '0 : kr_reg + 1'b1) : kr_reg;
    assign c_next   = (kc_end && kr_end) ? (c_end ? '0 : c_reg + 1'b1) : c_reg;

    assign sum     = acc_reg + ACCW'(prod_reg);
    assign shifted = sum >>> FRAC;
    assign sat_val = (shifted > MAXV) ? MAXV[BITWIDTH-1:0] :
                     (shifted < MINV) ? MINV[BITWIDTH-1:0] : shifted[BITWIDTH-1:0];
`ifdef CONV_LAYER_SEQ_RELU_EN
    assign res_val = sat_val[BITWIDTH-1] ? '0 : sat_val;
`else
    assign res_val = sat_val;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            c_reg     <= '0;
            kr_reg    <= '0;
            kc_reg    <= '0;
            prod_reg  <= '0;
            acc_reg   <= '0;
            last_reg  <= 1'b0;
            data_reg  <= '0;
            ch_reg    <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: if (start) begin
                    state_reg <= S_MAC;
                    c_reg     <= '0;
                    kr_reg    <= '0;
                    kc_reg    <= '0;
                    prod_reg  <= '0;
                    acc_reg   <= '0;
                    last_reg  <= 1'b0;
                    ch_reg    <= '0;
                    row_reg   <= '0;
                    col_reg   <= '0;
                end
                S_MAC: if (last_reg) begin
                    data_reg  <= res_val;
                    last_reg  <= 1'b0;
                    state_reg <= S_EMIT;
                end else begin
                    // Product register runs one tap ahead of the accumulator.
                    prod_reg <= prod;
                    acc_reg  <= sum;
                    last_reg <= tap_last;
                    c_reg    <= c_next;
                    kr_reg   <= kr_next;
                    kc_reg   <= kc_next;
                end
                S_EMIT: if (out_ready) begin
                    if (last_pix) begin
                        state_reg <= S_DONE;
                    end else begin
                        state_reg <= S_MAC;
                        ch_reg    <= nxt_ch;
                        row_reg   <= nxt_row;
                        col_reg   <= nxt_col;
                        acc_reg   <= '0;
                        prod_reg  <= prod;
                        last_reg  <= tap_last;
                        c_reg     <= c_next;
                        kr_reg    <= kr_next;
                        kc_reg    <= kc_next;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);
    assign out_valid = emit;
    assign out_data  = data_reg;
    assign out_ch    = ch_reg;
    assign out_row   = row_reg;
    assign out_col   = col_reg;
endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench for conv_layer_seq: a small 2x2x3x3 over 6x6 instance for most cases, plus a default-size all-ones pass.
module tb_conv_layer_seq;
`ifdef CONV_LAYER_SEQ_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start, out_ready, use_big;
    logic start_s, start_b;
    always #5 clk = ~clk;
    assign start_s = start & ~use_big;
    assign start_b = start & use_big;

    logic signed [15:0] fm_s [2][6][6];
    logic signed [15:0] k_s  [2][2][3][3];
    logic signed [15:0] fm_b [2][14][14];
    logic signed [15:0] k_b  [2][2][5][5];

    logic busy_s, done_s, valid_s, busy_b, done_b, valid_b;
    logic signed [15:0] data_s, data_b;
    logic [0:0] ch_s, ch_b;
    logic [1:0] row_s, col_s;
    logic [3:0] row_b, col_b;

    conv_layer_seq #(.BITWIDTH(16), .FRAC(8), .IN_CH(2), .OUT_CH(2), .KSIZE(3), .IN_DIM(6)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .featuremap(fm_s), .kernel(k_s),
        .busy(busy_s), .done(done_s), .out_valid(valid_s), .out_ready(out_ready),
        .out_data(data_s), .out_ch(ch_s), .out_row(row_s), .out_col(col_s));

    conv_layer_seq dut (
        .clk(clk), .rst(rst), .start(start_b), .featuremap(fm_b), .kernel(k_b),
        .busy(busy_b), .done(done_b), .out_valid(valid_b), .out_ready(out_ready),
        .out_data(data_b), .out_ch(ch_b), .out_row(row_b), .out_col(col_b));

    logic ob_busy, ob_done, ob_valid;
    logic [15:0] ob_data;
    int ob_ch, ob_row, ob_col;
    always_comb begin
        if (use_big) begin
            ob_busy = busy_b; ob_done = done_b; ob_valid = valid_b; ob_data = data_b;
            ob_ch = int'(ch_b); ob_row = int'(row_b); ob_col = int'(col_b);
        end else begin
            ob_busy = busy_s; ob_done = done_s; ob_valid = valid_s; ob_data = data_s;
            ob_ch = int'(ch_s); ob_row = int'(row_s); ob_col = int'(col_s);
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Hand-derived pixel values for each stimulus mode (n = taps per pixel).
    function automatic logic [15:0] exp_val(input int mode, input int n, input int o, input int r, input int c);
        int v;
        v = (r + 2) * 16 + (c + 2);
        case (mode)
            0: return 16'(n * 256);
            1: return 16'h7FFF;
            2: return RELU ? 16'h0000 : 16'h8000;
            3: return (o == 0) ? 16'h0000 : 16'(v);
            4: return (o == 0) ? 16'h0000 : 16'(v << 8);
            default: return RELU ? 16'h0000 : 16'hFFFF;
        endcase
    endfunction

    task automatic fill_small(input int mode);
        for (int ch = 0; ch < 2; ch++)
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 6; c++)
                    case (mode)
                        0: fm_s[ch][r][c] = 16'sh0100;
                        1, 2: fm_s[ch][r][c] = 16'sh6400;
                        3: fm_s[ch][r][c] = (ch == 0) ? 16'(r * 16 + c) : 16'sh7FFF;
                        4: fm_s[ch][r][c] = (ch == 0) ? 16'((r * 16 + c) << 8) : 16'sh7FFF;
                        default: fm_s[ch][r][c] = 16'sh0001;
                    endcase
        for (int o = 0; o < 2; o++)
            for (int ch = 0; ch < 2; ch++)
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        case (mode)
                            0, 1: k_s[o][ch][r][c] = 16'sh0100;
                            2: k_s[o][ch][r][c] = -16'sh0100;
                            3, 4: k_s[o][ch][r][c] = (o == 1 && ch == 0 && r == 2 && c == 2) ? 16'sh0100 : 16'sh0000;
                            default: k_s[o][ch][r][c] = -16'sh0001;
                        endcase
    endtask

    task automatic run_pass(input int mode, input bit big, input int stall_mode, input bit poke);
        int odim, och, n, pixels, exp_done, cnt, e, stalls, s0;
        bit finished;
        odim = big ? 10 : 4;
        och = 2;
        n = big ? 50 : 18;
        pixels = och * odim * odim;
        exp_done = pixels * (n + 1) + 1;
        cnt = 0; e = 0; stalls = 0; s0 = 0; finished = 1'b0;
        use_big = big;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!finished) begin
            chk("valid_done_excl", 64'(ob_valid & ob_done), 64'd0);
            if (ob_done) begin
                chk("pixel_count", 64'(e), 64'(pixels));
                chk("done_time", 64'(cnt), 64'(exp_done + stalls));
                finished = 1'b1;
            end else begin
                chk("busy", 64'(ob_busy), 64'd1);
                if (ob_valid) begin
                    if (e >= pixels) begin
                        chk("extra_pixel", 64'(e), 64'(pixels - 1));
                    end else begin
                        chk("out_data", 64'(ob_data), 64'(exp_val(mode, n, e / (odim * odim), (e / odim) % odim, e % odim)));
                        chk("out_col", 64'(ob_col), 64'(e % odim));
                        chk("out_row", 64'(ob_row), 64'((e / odim) % odim));
                        chk("out_ch", 64'(ob_ch), 64'(e / (odim * odim)));
                    end
                    if (stall_mode == 1 && e == 0 && s0 < 10) begin
                        out_ready = 1'b0;
                        s0++;
                    end else if (stall_mode == 1 && e > 0 && $urandom_range(0, 3) == 0) begin
                        out_ready = 1'b0;
                    end else begin
                        out_ready = 1'b1;
                    end
                    if (out_ready) e++;
                    else stalls++;
                end else begin
                    out_ready = 1'b1;
                end
                start = poke && (cnt == 100);
                if (cnt > exp_done + stalls + 50) begin
                    chk("done_timeout", 64'(cnt), 64'(exp_done + stalls));
                    finished = 1'b1;
                end else begin
                    @(negedge clk);
                    cnt++;
                end
            end
        end
        // A start seen in the DONE cycle must be dropped.
        start = poke;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("idle_after", 64'({ob_busy, ob_valid, ob_done}), 64'd0);
            @(negedge clk);
        end
        $display("pass mode=%0d big=%0d stall=%0d poke=%0d pixels=%0d done_at=%0d stalls=%0d",
                 mode, big, stall_mode, poke, e, cnt, stalls);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; use_big = 1'b0;
        for (int ch = 0; ch < 2; ch++)
            for (int r = 0; r < 14; r++)
                for (int c = 0; c < 14; c++)
                    fm_b[ch][r][c] = 16'sh0100;
        for (int o = 0; o < 2; o++)
            for (int ch = 0; ch < 2; ch++)
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++)
                        k_b[o][ch][r][c] = 16'sh0100;
        fill_small(0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_s), 64'd0);
        chk("rst_valid", 64'(valid_s), 64'd0);
        chk("rst_done", 64'(done_s), 64'd0);
        chk("rst_data", 64'(data_s), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Abort a pass during the second pixel's MAC phase.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        chk("mid_busy", 64'(busy_s), 64'd1);
        chk("mid_col", 64'(col_s), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy_s), 64'd0);
        chk("abort_valid", 64'(valid_s), 64'd0);
        chk("abort_done", 64'(done_s), 64'd0);
        chk("abort_data", 64'(data_s), 64'd0);
        chk("abort_idx", 64'({ch_s, row_s, col_s}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_done", 64'(done_s), 64'd0);

        run_pass(0, 1'b0, 0, 1'b0);
        fill_small(1); run_pass(1, 1'b0, 0, 1'b0);
        fill_small(2); run_pass(2, 1'b0, 0, 1'b0);
        fill_small(5); run_pass(5, 1'b0, 0, 1'b0);
        fill_small(3); run_pass(3, 1'b0, 0, 1'b0);
        fill_small(4); run_pass(4, 1'b0, 0, 1'b0);
        run_pass(4, 1'b0, 1, 1'b0);
        fill_small(0); run_pass(0, 1'b0, 0, 1'b1);
        run_pass(0, 1'b1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
